led_code_scheduler: RTL and testbench

LED_CODE_SCHEDULER -- requirements
Module: led_code_scheduler

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_tick_gen.sv | 37 +++
 rtl/led_code_scheduler.sv | 177 +++++++++++++++++
 tb/tb_led_code_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg
//   Shared types and constants for the LED blink-code scheduler.
//   state_t : scheduler FSM states
//   CODE_W  : width of one requester's blink count
//   max3    : helper used to size the per-state tick counter
package led_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//   Prescaler that turns the clk into a slow tick for the blink timing.
//   Counts 0..TICK_DIV-1 while run is high and pulses tick on the last
//   count. While run is low the count is held at zero, so each new run
//   starts a full TICK_DIV period.
// Ports
//   clk   in  clock
//   reset in  synchronous, active-high reset
//   run   in  enable counting
//   tick  out one-cycle pulse every TICK_DIV cycles while running
module led_tick_gen #(
  parameter int TICK_DIV = 10**7
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/led_code_scheduler.sv
// led_code_scheduler
//   Shares one PCB LED between NREQ requesters. Each requester asks for a
//   blink code (1..15 blinks); the scheduler grants round-robin, plays
//   code blinks of ON_TICKS lit / OFF_TICKS dark, then GAP_TICKS dark,
//   then pulses done. Dropping sys_en aborts the current sequence.
// Ports
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   sys_en in  enables scheduling; low aborts any sequence
//   req    in  [NREQ]          per-requester blink request (level)
//   code   in  [NREQ][CODE_W]  per-requester blink count, 0 = ignored
//   led    out LED drive, high = lit
//   grant  out [NREQ] one-hot owner of the playing code
//   busy   out high whenever not IDLE
//   done   out one-cycle pulse when a code completes normally
module led_code_scheduler
  import led_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 10**7,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sys_en,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0][CODE_W-1:0]  code,
  output logic                         led,
  output logic [NREQ-1:0]              grant,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_TICKS = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam int TCNT_W    = $clog2(MAX_TICKS + 1);

  localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
  localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

  state_t              state, state_n;
  logic [CODE_W-1:0]   remaining, remaining_n;
  logic [TCNT_W-1:0]   tick_cnt, tick_cnt_n;
  logic [IDX_W-1:0]    last_granted, last_granted_n;
  logic [NREQ-1:0]     grant_n;
  logic                led_n, busy_n, done_n;
  logic                tick;
  logic                found;
  logic [IDX_W-1:0]    sel;
  logic [CODE_W-1:0]   remaining_dec;

  // The prescaler runs off the registered busy flag, so it is held at zero
  // through the mandatory IDLE cycle and every sequence starts in phase.
  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (busy),
    .tick  (tick)
  );

  // Round-robin search beginning just after the last owner; requesters
  // with a zero code never qualify.
  always_comb begin
    found = 1'b0;
    sel   = last_granted;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_granted) + k) % NREQ] &&
          (code[(int'(last_granted) + k) % NREQ] != '0)) begin
        found = 1'b1;
        sel   = IDX_W'((int'(last_granted) + k) % NREQ);
      end
    end
  end

  assign remaining_dec = remaining - CODE_W'(1);

  // Next-state logic. Outputs are derived from the next state so that they
  // can be registered alongside it and line up with the state they reflect.
  always_comb begin
    state_n        = state;
    remaining_n    = remaining;
    tick_cnt_n     = tick_cnt;
    last_granted_n = last_granted;
    grant_n        = grant;
    done_n         = 1'b0;

    case (state)
      IDLE: begin
        if (sys_en && found) begin
          state_n        = ON;
          remaining_n    = code[sel];
          last_granted_n = sel;
          grant_n        = '0;
          grant_n[sel]   = 1'b1;
          tick_cnt_n     = '0;
        end
      end
      ON: begin
        if (tick) begin
          if (tick_cnt == ON_LAST) begin
            state_n    = OFF;
            tick_cnt_n = '0;
          end else begin
            tick_cnt_n = tick_cnt + TCNT_W'(1);
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (tick_cnt == OFF_LAST) begin
            remaining_n = remaining_dec;
            tick_cnt_n  = '0;
            state_n     = (remaining_dec != '0) ? ON : GAP;
          end else begin
            tick_cnt_n = tick_cnt + TCNT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tick_cnt == GAP_LAST) begin
            state_n    = IDLE;
            tick_cnt_n = '0;
            grant_n    = '0;
            done_n     = 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + TCNT_W'(1);
          end
        end
      end
      default: begin
        state_n    = IDLE;
        tick_cnt_n = '0;
        grant_n    = '0;
      end
    endcase

    // An abort keeps last_granted so the aborted requester loses its turn.
    if (!sys_en && (state != IDLE)) begin
      state_n    = IDLE;
      tick_cnt_n = '0;
      grant_n    = '0;
      done_n     = 1'b0;
    end

    led_n  = (state_n == ON);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      tick_cnt     <= '0;
      last_granted <= IDX_W'(NREQ - 1);
      grant        <= '0;
      led          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      remaining    <= remaining_n;
      tick_cnt     <= tick_cnt_n;
      last_granted <= last_granted_n;
      grant        <= grant_n;
      led          <= led_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_led_code_scheduler.sv
// tb_led_code_scheduler
//   Directed bench for led_code_scheduler with a small prescaler. Expected
//   grants and blink counts are queued when a request is driven and are
//   popped when the scheduler starts playing a code.
module tb_led_code_scheduler;
  import led_pkg::*;

  localparam int TD    = 4;
  localparam int ONT   = 2;
  localparam int OFFT  = 2;
  localparam int GAPT  = 3;
  localparam int BLINK = (ONT + OFFT) * TD;
  localparam int LIT   = ONT * TD;
  localparam int GAPC  = GAPT * TD;

  typedef struct {
    logic [3:0] grant;
    int         blinks;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sys_en;
  logic [3:0]             req;
  logic [3:0][CODE_W-1:0] code;
  logic                   led;
  logic [3:0]             grant;
  logic                   busy;
  logic                   done;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  led_code_scheduler #(
    .NREQ      (4),
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT),
    .GAP_TICKS (GAPT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sys_en (sys_en),
    .req    (req),
    .code   (code),
    .led    (led),
    .grant  (grant),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant and compares it with the scoreboard head.
  task automatic wait_grant(input string name, input int exp_lat, output exp_t e, output bit ok);
    int lat;
    ok = 1'b0;
    e.grant  = 4'b0000;
    e.blinks = 0;
    check({name, " sb_has_entry"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) e = sb.pop_front();
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (grant != 4'b0000) break;
    end
    check({name, " grant_seen"}, 32'(grant != 4'b0000), 1);
    if (grant == 4'b0000) return;
    check({name, " grant"}, 32'(grant), 32'(e.grant));
    if (exp_lat > 0) check({name, " latency"}, lat, exp_lat);
    ok = 1'b1;
  endtask

  // Follows one full sequence cycle by cycle; returns on the done cycle.
  task automatic observe(input string name, input int exp_lat, input int change_at,
                         input logic [3:0] req_new, input logic [3:0][CODE_W-1:0] code_new);
    exp_t e;
    bit   ok;
    int   len;
    logic exp_led;
    wait_grant(name, exp_lat, e, ok);
    if (!ok) return;
    len = e.blinks * BLINK + GAPC;
    for (int c = 0; c < len; c++) begin
      exp_led = (c < e.blinks * BLINK) && ((c % BLINK) < LIT);
      check($sformatf("%s c%0d {led,busy,done,grant}", name, c),
            32'({led, busy, done, grant}), 32'({exp_led, 1'b1, 1'b0, e.grant}));
      if (c == change_at) begin
        req  = req_new;
        code = code_new;
      end
      @(negedge clk);
    end
    check($sformatf("%s done_cycle {led,busy,done,grant}", name),
          32'({led, busy, done, grant}), 32'({1'b0, 1'b0, 1'b1, 4'b0000}));
  endtask

  initial begin
    exp_t e;
    bit   ok;
    logic [3:0][CODE_W-1:0] code_tmp;

    reset  = 1'b1;
    sys_en = 1'b0;
    req    = 4'b0000;
    code   = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({led, busy, done, grant}), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'({led, busy, done, grant}), 32'(0));

    // Single requester, three blinks.
    sys_en  = 1'b1;
    code[0] = 4'd3;
    req     = 4'b0001;
    sb.push_back('{4'b0001, 3});
    observe("s1", 1, 1, 4'b0000, code);

    // Two requesters alternate, one IDLE cycle between sequences.
    @(negedge clk);
    apply_reset();
    sys_en = 1'b1;
    code   = {4'd1, 4'd1, 4'd1, 4'd1};
    req    = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{(i % 2 == 0) ? 4'b0001 : 4'b0100, 1});
      observe($sformatf("s2_%0d", i), 1, (i == 3) ? 1 : -1,
              (i == 3) ? 4'b0000 : 4'b0101, code);
    end

    // Zero code is never granted.
    code    = '0;
    code[1] = 4'd2;
    req     = 4'b0011;
    sb.push_back('{4'b0010, 2});
    observe("s3", 1, 1, 4'b0001, code);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("s3 code0_ignored %0d {busy,grant}", i), 32'({busy, grant}), 32'(0));
    end

    // Abort in the fifth ON cycle, then resume after the aborted requester.
    req     = 4'b0100;
    code[2] = 4'd2;
    sb.push_back('{4'b0100, 2});
    wait_grant("s4", 1, e, ok);
    repeat (4) @(negedge clk);
    check("s4 still_on led", 32'(led), 1);
    sys_en = 1'b0;
    @(negedge clk);
    check("s4 abort {led,busy,done,grant}", 32'({led, busy, done, grant}), 32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("s4 no_done %0d {busy,done}", i), 32'({busy, done}), 32'(0));
    end
    sys_en = 1'b1;
    req    = 4'b1111;
    code   = {4'd1, 4'd1, 4'd1, 4'd1};
    sb.push_back('{4'b1000, 1});
    observe("s4b", 1, 1, 4'b0000, code);

    // Request and code change during the first OFF do not alter the run.
    code[0] = 4'd2;
    req     = 4'b0001;
    code_tmp = {4'd5, 4'd5, 4'd5, 4'd5};
    sb.push_back('{4'b0001, 2});
    observe("s5", 1, LIT + 2, 4'b0000, code_tmp);

    // Reset during GAP, then the first grant goes to the new requester.
    code[1] = 4'd1;
    req     = 4'b0010;
    sb.push_back('{4'b0010, 1});
    wait_grant("s6", 1, e, ok);
    repeat (20) @(negedge clk);
    check("s6 in_gap {led,busy}", 32'({led, busy}), 32'({1'b0, 1'b1}));
    reset = 1'b1;
    @(negedge clk);
    check("s6 reset {led,busy,done,grant}", 32'({led, busy, done, grant}), 32'(0));
    req     = 4'b1000;
    code[3] = 4'd1;
    reset   = 1'b0;
    sb.push_back('{4'b1000, 1});
    observe("s6b", 1, 1, 4'b0000, code);

    check("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
